// File: rtl/mram_sync.sv
// mram_sync: synchronous single-port RAM with a registered read port, a
// one-cycle read-valid pulse and a hardware clear engine that zero-fills the
// array after reset or when clr is requested.
// Optional feature macro: RAM_PARITY_EN. When it is defined, each word carries
// an even-parity bit and the par_err output is present.
`timescale 1ns/1ps

module mram_sync #(
   parameter int ADDR_SIZE   = 4,
   parameter int WORD_SIZE   = 8,
   parameter int MEMORY_SIZE = 16,
   parameter bit READ_FIRST  = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cs,
   input  logic                 wr,
   input  logic                 rd,
   input  logic                 clr,
   input  logic [ADDR_SIZE-1:0] addr,
   input  logic [WORD_SIZE-1:0] data_in,
   output logic [WORD_SIZE-1:0] data_out,
   output logic                 rd_valid,
   output logic                 busy,
`ifdef RAM_PARITY_EN
   output logic                 par_err,
`endif
   output logic                 addr_err
);

`ifdef RAM_PARITY_EN
   // Stored word = {parity, data}
   localparam int MW = WORD_SIZE + 1;
`else
   localparam int MW = WORD_SIZE;
`endif

   // Last word index written by the clear engine
   localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEMORY_SIZE - 1);
   // Address limit, one bit wider so MEMORY_SIZE == 2**ADDR_SIZE is representable
   localparam logic [ADDR_SIZE:0]   MEM_LIMIT = (ADDR_SIZE + 1)'(MEMORY_SIZE);
   localparam logic [ADDR_SIZE-1:0] CNT_ONE   = ADDR_SIZE'(1'b1);

`ifdef RAM_PARITY_EN
   // Even-parity bit: makes the total number of ones (data + parity) even
   function automatic logic parity_f(input logic [WORD_SIZE-1:0] d);
      return ^d;
   endfunction
`endif

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                state_r;
   state_t                state_s;
   logic [ADDR_SIZE-1:0]  clr_cnt_r;
   logic [ADDR_SIZE-1:0]  clr_cnt_s;

   logic [MW-1:0]         mem_r [0:MEMORY_SIZE-1];

   logic                  acc_s;
   logic                  wr_acc_s;
   logic                  rd_acc_s;
   logic                  in_range_s;
   logic [MW-1:0]         rd_word_s;
   logic [WORD_SIZE-1:0]  rd_data_s;
`ifdef RAM_PARITY_EN
   logic                  rd_par_err_s;
`endif

   logic                  mem_we_s;
   logic [ADDR_SIZE-1:0]  mem_waddr_s;
   logic [MW-1:0]         mem_wdata_s;

   // Next-state logic for the fill/serve FSM; clr always wins and restarts the fill
   always_comb begin
      state_s   = state_r;
      clr_cnt_s = clr_cnt_r;
      case (state_r)
         ST_INIT: begin
            if (clr) begin
               clr_cnt_s = '0;
            end else if (clr_cnt_r == LAST_ADDR) begin
               state_s   = ST_READY;
               clr_cnt_s = '0;
            end else begin
               clr_cnt_s = clr_cnt_r + CNT_ONE;
            end
         end
         ST_READY: begin
            if (clr) begin
               state_s   = ST_INIT;
               clr_cnt_s = '0;
            end else begin
               state_s   = ST_READY;
               clr_cnt_s = clr_cnt_r;
            end
         end
         default: begin
            state_s   = ST_INIT;
            clr_cnt_s = '0;
         end
      endcase
   end

   // FSM state, fill counter and registered busy flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_INIT;
         clr_cnt_r <= '0;
         busy      <= 1'b1;
      end else begin
         state_r   <= state_s;
         clr_cnt_r <= clr_cnt_s;
         busy      <= (state_s == ST_INIT);
      end
   end

   // Access qualification against the registered state; clr drops any access
   always_comb begin
      acc_s      = (state_r == ST_READY) && cs && !clr;
      wr_acc_s   = acc_s && wr;
      rd_acc_s   = acc_s && rd;
      in_range_s = ({1'b0, addr} < MEM_LIMIT);
   end

   // Read-data selection: out-of-range reads return zero, write-through when new data is wanted
   always_comb begin
      rd_word_s = '0;
      rd_data_s = '0;
`ifdef RAM_PARITY_EN
      rd_par_err_s = 1'b0;
`endif
      if (!in_range_s) begin
         rd_word_s = '0;
         rd_data_s = '0;
      end else if (wr && !READ_FIRST) begin
         rd_word_s = mem_r[addr];
         rd_data_s = data_in;
      end else begin
         rd_word_s = mem_r[addr];
         rd_data_s = rd_word_s[WORD_SIZE-1:0];
`ifdef RAM_PARITY_EN
         rd_par_err_s = (parity_f(rd_word_s[WORD_SIZE-1:0]) != rd_word_s[WORD_SIZE]);
`endif
      end
   end

   // Array write port shared between the clear engine and accepted writes
   always_comb begin
      mem_we_s    = 1'b0;
      mem_waddr_s = '0;
      mem_wdata_s = '0;
      if (state_r == ST_INIT) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = clr_cnt_r;
         mem_wdata_s = '0;
      end else if (wr_acc_s && in_range_s) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = addr;
`ifdef RAM_PARITY_EN
         mem_wdata_s = {parity_f(data_in), data_in};
`else
         mem_wdata_s = data_in;
`endif
      end else begin
         mem_we_s    = 1'b0;
         mem_waddr_s = '0;
         mem_wdata_s = '0;
      end
   end

   // Storage array; contents are undefined until the first fill completes
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[mem_waddr_s] <= mem_wdata_s;
      end
   end

   // Registered read data and single-cycle status pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out <= '0;
         rd_valid <= 1'b0;
         addr_err <= 1'b0;
`ifdef RAM_PARITY_EN
         par_err  <= 1'b0;
`endif
      end else begin
         rd_valid <= rd_acc_s;
         addr_err <= (wr_acc_s || rd_acc_s) && !in_range_s;
`ifdef RAM_PARITY_EN
         par_err  <= rd_acc_s && rd_par_err_s;
`endif
         if (rd_acc_s) begin
            data_out <= rd_data_s;
         end
      end
   end

endmodule

// File: tb/tb_mram_sync.sv
// Self-checking bench for mram_sync. Two instances share stimulus:
// instance 0 has 16 words with READ_FIRST=1, instance 1 has 12 words with
// READ_FIRST=0. A behavioural model tracks expected outputs of both.
`timescale 1ns/1ps

module tb_mram_sync;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cs = 1'b0, wr = 1'b0, rd = 1'b0, clr = 1'b0;
   logic [3:0] addr = 4'd0;
   logic [7:0] data_in = 8'd0;

   logic [7:0] dout [2];
   logic       rv   [2];
   logic       ae   [2];
   logic       busy [2];
`ifdef RAM_PARITY_EN
   logic       pe   [2];
`endif

   always #5 clk = ~clk;

   mram_sync #(.ADDR_SIZE(4), .WORD_SIZE(8), .MEMORY_SIZE(16), .READ_FIRST(1'b1)) dut16 (
      .clk(clk), .rst(rst), .cs(cs), .wr(wr), .rd(rd), .clr(clr), .addr(addr),
      .data_in(data_in), .data_out(dout[0]), .rd_valid(rv[0]), .busy(busy[0]),
`ifdef RAM_PARITY_EN
      .par_err(pe[0]),
`endif
      .addr_err(ae[0]));

   mram_sync #(.ADDR_SIZE(4), .WORD_SIZE(8), .MEMORY_SIZE(12), .READ_FIRST(1'b0)) dut12 (
      .clk(clk), .rst(rst), .cs(cs), .wr(wr), .rd(rd), .clr(clr), .addr(addr),
      .data_in(data_in), .data_out(dout[1]), .rd_valid(rv[1]), .busy(busy[1]),
`ifdef RAM_PARITY_EN
      .par_err(pe[1]),
`endif
      .addr_err(ae[1]));

   // ---------------- behavioural reference model ----------------
   int         ms [2] = '{16, 12};
   bit         rf [2] = '{1'b1, 1'b0};
   logic [7:0] mm [2][16];
   int         fill_left [2];
   logic [7:0] e_dout [2];
   logic       e_rv [2], e_ae [2], e_busy [2];

   int n_checks = 0;
   int n_pass   = 0;

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         fill_left[i] = ms[i];
         e_busy[i] = 1'b1; e_dout[i] = 8'd0; e_rv[i] = 1'b0; e_ae[i] = 1'b0;
      end
   endfunction

   // Applies one rising edge with the current inputs
   function automatic void model_edge();
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            fill_left[i] = ms[i];
            e_busy[i] = 1'b1; e_dout[i] = 8'd0; e_rv[i] = 1'b0; e_ae[i] = 1'b0;
         end else if (clr) begin
            fill_left[i] = ms[i];
            e_busy[i] = 1'b1; e_rv[i] = 1'b0; e_ae[i] = 1'b0;
         end else if (e_busy[i]) begin
            e_rv[i] = 1'b0; e_ae[i] = 1'b0;
            fill_left[i] = fill_left[i] - 1;
            if (fill_left[i] == 0) begin
               e_busy[i] = 1'b0;
               for (int j = 0; j < 16; j++) mm[i][j] = 8'd0;
            end
         end else begin
            e_rv[i] = 1'b0; e_ae[i] = 1'b0;
            if (cs && (wr || rd)) begin
               e_ae[i] = (int'(addr) >= ms[i]);
               if (rd) begin
                  e_rv[i] = 1'b1;
                  if (int'(addr) >= ms[i]) e_dout[i] = 8'd0;
                  else if (wr && !rf[i]) e_dout[i] = data_in;
                  else e_dout[i] = mm[i][addr];
               end
               if (wr && int'(addr) < ms[i]) mm[i][addr] = data_in;
            end
         end
      end
   endfunction

   // Drive one cycle of stimulus, advance the model, sample 1 time unit after the edge
   task automatic step(input logic c, w, r, cl, input logic [3:0] a, input logic [7:0] d);
      cs = c; wr = w; rd = r; clr = cl; addr = a; data_in = d;
      @(posedge clk);
      model_edge();
      #1;
      cs = 1'b0; wr = 1'b0; rd = 1'b0; clr = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int fall [2];
      @(posedge clk); @(posedge clk); #1;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         n_checks++; if (dout[i] !== 8'd0) $display("FAIL reset_dout inst%0d got %h want 00", i, dout[i]); else n_pass++;
         n_checks++; if (rv[i] !== 1'b0) $display("FAIL reset_rv inst%0d got %b want 0", i, rv[i]); else n_pass++;
         n_checks++; if (ae[i] !== 1'b0) $display("FAIL reset_ae inst%0d got %b want 0", i, ae[i]); else n_pass++;
         n_checks++; if (busy[i] !== 1'b1) $display("FAIL reset_busy inst%0d got %b want 1", i, busy[i]); else n_pass++;
         fall[i] = 0;
      end
      rst = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
         for (int i = 0; i < 2; i++)
            if (busy[i] === 1'b0 && fall[i] == 0) fall[i] = k;
      end
      n_checks++; if (fall[0] != 16) $display("FAIL fill_len16 got %0d want 16", fall[0]); else n_pass++;
      n_checks++; if (fall[1] != 12) $display("FAIL fill_len12 got %0d want 12", fall[1]); else n_pass++;
      for (int a = 0; a < 16; a++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0, 4'(a), 8'd0);
         for (int i = 0; i < 2; i++) begin
            n_checks++; if (dout[i] !== 8'd0 || rv[i] !== 1'b1)
               $display("FAIL zero_read inst%0d a=%0d got %h/%b want 00/1", i, a, dout[i], rv[i]); else n_pass++;
         end
      end
   endtask

   task automatic test_write_read();
      for (int k = 0; k < 16; k++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 4'(k), 8'((k + k) % 256));
         n_checks++; if (rv[0] !== 1'b0) $display("FAIL wr_no_rv k=%0d got %b want 0", k, rv[0]); else n_pass++;
         n_checks++; if (ae[1] !== (k >= 12)) $display("FAIL wr_ae12 k=%0d got %b want %b", k, ae[1], k >= 12); else n_pass++;
      end
      for (int k = 15; k >= 0; k--) begin
         step(1'b1, 1'b0, 1'b1, 1'b0, 4'(k), 8'd0);
         n_checks++; if (dout[0] !== 8'(2 * k) || rv[0] !== 1'b1)
            $display("FAIL rev_read16 k=%0d got %h/%b want %h/1", k, dout[0], rv[0], 8'(2 * k)); else n_pass++;
         n_checks++; if (dout[1] !== ((k < 12) ? 8'(2 * k) : 8'd0) || rv[1] !== 1'b1)
            $display("FAIL rev_read12 k=%0d got %h/%b want %h/1", k, dout[1], rv[1], (k < 12) ? 8'(2 * k) : 8'd0); else n_pass++;
      end
   endtask

   task automatic test_rw_same();
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 8'h55);
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 8'hAA);
      n_checks++; if (dout[0] !== 8'h55 || rv[0] !== 1'b1) $display("FAIL rw_read_first got %h want 55", dout[0]); else n_pass++;
      n_checks++; if (dout[1] !== 8'hAA || rv[1] !== 1'b1) $display("FAIL rw_write_first got %h want aa", dout[1]); else n_pass++;
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
      for (int i = 0; i < 2; i++) begin
         n_checks++; if (dout[i] !== 8'hAA) $display("FAIL rw_after inst%0d got %h want aa", i, dout[i]); else n_pass++;
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      for (int i = 0; i < 2; i++) begin
         n_checks++; if (dout[i] !== 8'hAA || rv[i] !== 1'b0)
            $display("FAIL idle_hold inst%0d got %h/%b want aa/0", i, dout[i], rv[i]); else n_pass++;
      end
   endtask

   task automatic test_addr_err();
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd13, 8'h77);
      n_checks++; if (ae[1] !== 1'b1 || rv[1] !== 1'b0) $display("FAIL oor_write_ae got %b/%b want 1/0", ae[1], rv[1]); else n_pass++;
      n_checks++; if (ae[0] !== 1'b0) $display("FAIL inr_write_ae got %b want 0", ae[0]); else n_pass++;
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      n_checks++; if (ae[1] !== 1'b0) $display("FAIL ae_pulse got %b want 0", ae[1]); else n_pass++;
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd13, 8'h00);
      n_checks++; if (dout[1] !== 8'h00 || ae[1] !== 1'b1 || rv[1] !== 1'b1)
         $display("FAIL oor_read got %h/%b/%b want 00/1/1", dout[1], ae[1], rv[1]); else n_pass++;
      n_checks++; if (dout[0] !== 8'h77 || ae[0] !== 1'b0) $display("FAIL inr_read13 got %h/%b want 77/0", dout[0], ae[0]); else n_pass++;
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd13, 8'h12);
      for (int i = 0; i < 2; i++) begin
         n_checks++; if (rv[i] !== 1'b0 || ae[i] !== 1'b0 || dout[i] !== e_dout[i])
            $display("FAIL cs_low inst%0d got %h/%b/%b want %h/0/0", i, dout[i], rv[i], ae[i], e_dout[i]); else n_pass++;
      end
   endtask

   task automatic test_clr();
      int fall [2];
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 8'hF5);
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 8'h00);
      step(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 8'h11);
      for (int i = 0; i < 2; i++) begin
         n_checks++; if (busy[i] !== 1'b1 || rv[i] !== 1'b0) $display("FAIL clr_busy inst%0d got %b/%b want 1/0", i, busy[i], rv[i]); else n_pass++;
      end
      for (int k = 0; k < 11; k++) begin
         step(1'b1, 1'b1, 1'(k % 2), 1'b0, 4'($urandom_range(0, 15)), 8'hFF);
         for (int i = 0; i < 2; i++) begin
            n_checks++; if (rv[i] !== 1'b0 || dout[i] !== 8'hF5 || busy[i] !== e_busy[i])
               $display("FAIL clr_ignore inst%0d k=%0d got %h/%b/%b want f5/0/%b", i, k, dout[i], rv[i], busy[i], e_busy[i]); else n_pass++;
         end
      end
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      for (int a = 0; a < 16; a++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0, 4'(a), 8'h00);
         for (int i = 0; i < 2; i++) begin
            n_checks++; if (dout[i] !== 8'd0 || rv[i] !== 1'b1)
               $display("FAIL clr_zero inst%0d a=%0d got %h/%b want 00/1", i, a, dout[i], rv[i]); else n_pass++;
         end
      end
      // reset in the middle of a fill
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 8'h3C);
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      n_checks++; if (dout[0] !== 8'h3C) $display("FAIL fill_hold got %h want 3c", dout[0]); else n_pass++;
      rst = 1'b1;
      #1;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         n_checks++; if (dout[i] !== 8'd0 || busy[i] !== 1'b1 || rv[i] !== 1'b0)
            $display("FAIL midfill_rst inst%0d got %h/%b/%b want 00/1/0", i, dout[i], busy[i], rv[i]); else n_pass++;
         fall[i] = 0;
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
         for (int i = 0; i < 2; i++)
            if (busy[i] === 1'b0 && fall[i] == 0) fall[i] = k;
      end
      n_checks++; if (fall[0] != 16) $display("FAIL refill_len16 got %0d want 16", fall[0]); else n_pass++;
      n_checks++; if (fall[1] != 12) $display("FAIL refill_len12 got %0d want 12", fall[1]); else n_pass++;
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
         for (int i = 0; i < 2; i++) begin
            n_checks++; if (dout[i] !== e_dout[i] || rv[i] !== e_rv[i] || ae[i] !== e_ae[i] || busy[i] !== e_busy[i])
               $display("FAIL random inst%0d k=%0d got %h/%b/%b/%b want %h/%b/%b/%b", i, k,
                        dout[i], rv[i], ae[i], busy[i], e_dout[i], e_rv[i], e_ae[i], e_busy[i]); else n_pass++;
         end
      end
   endtask

`ifdef RAM_PARITY_EN
   task automatic test_parity();
      for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 8'h0F);
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 8'h13);
      dut16.mem_r[2][0] = ~dut16.mem_r[2][0];
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 8'h00);
      n_checks++; if (dout[0] !== 8'h0E || pe[0] !== 1'b1 || rv[0] !== 1'b1)
         $display("FAIL par_flip got %h/%b want 0e/1", dout[0], pe[0]); else n_pass++;
      n_checks++; if (dout[1] !== 8'h0F || pe[1] !== 1'b0) $display("FAIL par_clean got %h/%b want 0f/0", dout[1], pe[1]); else n_pass++;
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 8'h00);
      n_checks++; if (dout[0] !== 8'h13 || pe[0] !== 1'b0) $display("FAIL par_other got %h/%b want 13/0", dout[0], pe[0]); else n_pass++;
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd14, 8'h00);
      n_checks++; if (pe[1] !== 1'b0 || ae[1] !== 1'b1) $display("FAIL par_oor got %b/%b want 0/1", pe[1], ae[1]); else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_write_read();
      test_rw_same();
      test_addr_err();
      test_clr();
      test_random();
`ifdef RAM_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
